dram_uart_tx: RTL and testbench
===============================

Name: dram_uart_tx

Overview:
- Responder to the control state machine's `start_Tx` completion flag.
- On a rising edge of `start_Tx`, reads a contiguous block of result bytes out of DRAM and serialises each one on a UART line, 8N1, LSB first.
- Sits between the DRAM read port and the board's TX pin; it is the only DRAM reader once the processor has reached its end state.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535
- ADDR_WIDTH, 16, DRAM address width
- BASE_ADDR, 0, first DRAM address transmitted
- NUM_BYTES, 65536, number of bytes transmitted per transfer; legal range 1..2^ADDR_WIDTH

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start_Tx  input  1  completion flag from the control state machine; level input, rising edge triggers a transfer
- dram_data  input  8  DRAM read data; valid one cycle after dram_addr changes (registered read)
- dram_addr  output  ADDR_WIDTH  DRAM read address
- tx  output  1  UART serial output; idle high
- busy  output  1  high from transfer accept until the final stop bit ends
- done  output  1  transfer-complete flag

Behaviour:
- Reset values (applied at the first rising edge with reset high; clock and reset are the only timing inputs):
  - tx=1, busy=0, done=0
  - dram_addr=BASE_ADDR
  - start_q=0, byte counter=0, bit counter=0, baud counter=0
  - state=IDLE
- Edge detect:
  - start_q registers start_Tx every cycle.
  - Trigger = start_Tx & ~start_q, evaluated in IDLE only.
  - Because start_q resets to 0, start_Tx already high when reset releases triggers exactly one transfer.
  - Edges outside IDLE are ignored; there is no queuing.
- IDLE: tx=1, busy=0. On trigger -> READ, busy=1, dram_addr=BASE_ADDR.
- READ: one cycle with the address held stable -> LATCH.
- LATCH: shift_reg<=dram_data -> START, baud counter cleared.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit counter=0.
- DATA:
  - tx=shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - After bit 7 -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then:
  - if byte counter==NUM_BYTES-1 -> DONE;
  - otherwise byte counter+1, dram_addr+1 (wraps modulo 2^ADDR_WIDTH), -> READ.
- DONE:
  - busy=0, done=1, tx=1.
  - Stays while start_Tx=1. When start_Tx=0 -> IDLE, done=0.
  - If start_Tx is already low on entry, done is high for exactly one cycle.
- Timing:
  - tx falls 2 cycles after the edge that samples the trigger (READ, LATCH).
  - Frame = 10*CLKS_PER_BIT cycles.
  - Byte-to-byte period = 10*CLKS_PER_BIT+2 cycles; the READ/LATCH gap is idle-high.
  - Total transfer = NUM_BYTES*(10*CLKS_PER_BIT+2) cycles from trigger to DONE.
- Counter widths:
  - Baud counter: ceil(log2(CLKS_PER_BIT)) bits, terminal count CLKS_PER_BIT-1.
  - Byte counter: ADDR_WIDTH+1 bits so that NUM_BYTES=2^ADDR_WIDTH is legal.
- start_Tx falling mid-transfer has no effect; the transfer completes and DONE then exits after one cycle.
- Reset mid-frame: on the next edge tx=1, the state returns to IDLE, all counters clear and the partial byte is abandoned.
- tx is driven from a register, glitch-free. No combinational path from any input to tx.

Test Plan:
- Single byte (CLKS_PER_BIT=4, NUM_BYTES=1), DRAM[0]=0xA5, pulse start_Tx high and hold:
  - tx low 2 cycles after the trigger, then bits 1,0,1,0,0,1,0,1, then stop high, each 4 cycles;
  - done=1 after 42 cycles and held while start_Tx=1.
- Multi-byte (NUM_BYTES=3), DRAM[0..2]=0xA5,0x3C,0xFF:
  - dram_addr steps 0,1,2;
  - bench UART decoder receives A5,3C,FF;
  - start-bit falls are 42 cycles apart;
  - busy falls and done rises after 126 cycles.
- start_Tx already high at reset release -> exactly one transfer. Hold start_Tx high afterwards -> no second transfer. Drop start_Tx and raise it again -> second identical transfer.
- Reset asserted during DATA bit 3 -> next edge tx=1, busy=0, dram_addr=BASE_ADDR. A fresh trigger restarts from byte 0.
- start_Tx dropped during byte 1 of 3 -> all 3 bytes are still sent, done pulses high for exactly one cycle, and the state returns to IDLE.
- Address wrap (ADDR_WIDTH=4, BASE_ADDR=14, NUM_BYTES=4) -> dram_addr sequence 14,15,0,1.

Source files
------------

// File: rtl/dram_uart_tx.sv
// dram_uart_tx: streams a contiguous DRAM byte block out of an 8N1 UART line on a start_Tx rising edge
module dram_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR = 0,
  parameter int NUM_BYTES = 65536
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_Tx,
  input  logic [7:0]            dram_data,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(NUM_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  typedef enum logic [2:0] {IDLE, READ, LATCH, START, DATA, STOP, DONE} state_t;
  state_t state, state_n;
  logic start_q;
  logic [ADDR_WIDTH:0] byte_cnt, byte_n;
  logic [2:0] bit_cnt, bit_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [7:0] shift_reg, shift_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic tx_n, baud_end;
  // state and datapath registers; tx is registered so the line never glitches
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      start_q <= 1'b0;
      byte_cnt <= '0;
      bit_cnt <= '0;
      baud_cnt <= '0;
      shift_reg <= '0;
      dram_addr <= BASE;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      start_q <= start_Tx;
      byte_cnt <= byte_n;
      bit_cnt <= bit_n;
      baud_cnt <= baud_n;
      shift_reg <= shift_n;
      dram_addr <= addr_n;
      tx <= tx_n;
    end
  end
  // next-state logic; the tx level follows the state being entered so it lines up with the edge
  always_comb begin
    state_n = state;
    byte_n = byte_cnt;
    bit_n = bit_cnt;
    shift_n = shift_reg;
    addr_n = dram_addr;
    baud_end = baud_cnt == BAUD_TC;
    baud_n = baud_end ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (start_Tx & ~start_q) begin
          state_n = READ;
          addr_n = BASE;
          byte_n = '0;
        end
      end
      READ: begin
        baud_n = '0;
        state_n = LATCH;
      end
      LATCH: begin
        baud_n = '0;
        shift_n = dram_data;
        state_n = START;
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          bit_n = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_n = shift_reg >> 1;
          bit_n = bit_cnt + 1'b1;
          state_n = bit_cnt == 3'd7 ? STOP : DATA;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (byte_cnt == LAST) state_n = DONE;
          else begin
            byte_n = byte_cnt + 1'b1;
            addr_n = dram_addr + 1'b1;
            state_n = READ;
          end
        end
      end
      DONE: begin
        baud_n = '0;
        state_n = start_Tx ? DONE : IDLE;
      end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
endmodule

// File: tb/tb_dram_uart_tx.sv
// tb_dram_uart_tx: directed checks of single-byte, multi-byte, retrigger, reset and address-wrap transfers
module tb_dram_uart_tx;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic r1 = 1'b1, r3 = 1'b1, rw = 1'b1;
  logic s1 = 1'b0, s3 = 1'b0, sw = 1'b0;
  logic [7:0] d1, d3, dw;
  logic [15:0] a1, a3;
  logic [3:0] aw;
  logic t1, t3, tw, b1, b3, bw, o1, o3, ow;
  int checks = 0, errors = 0;
  dram_uart_tx #(.CLKS_PER_BIT(4), .ADDR_WIDTH(16), .BASE_ADDR(0), .NUM_BYTES(1)) u1 (
    .clock(clock), .reset(r1), .start_Tx(s1), .dram_data(d1), .dram_addr(a1), .tx(t1), .busy(b1), .done(o1));
  dram_uart_tx #(.CLKS_PER_BIT(4), .ADDR_WIDTH(16), .BASE_ADDR(0), .NUM_BYTES(3)) u3 (
    .clock(clock), .reset(r3), .start_Tx(s3), .dram_data(d3), .dram_addr(a3), .tx(t3), .busy(b3), .done(o3));
  dram_uart_tx #(.CLKS_PER_BIT(4), .ADDR_WIDTH(4), .BASE_ADDR(14), .NUM_BYTES(4)) uw (
    .clock(clock), .reset(rw), .start_Tx(sw), .dram_data(dw), .dram_addr(aw), .tx(tw), .busy(bw), .done(ow));
  // registered-read DRAM models
  always_ff @(posedge clock) begin
    d1 <= a1 == 16'd0 ? 8'hA5 : 8'h00;
    d3 <= a3 == 16'd0 ? 8'hA5 : a3 == 16'd1 ? 8'h3C : a3 == 16'd2 ? 8'hFF : 8'h00;
    dw <= aw == 4'd14 ? 8'h11 : aw == 4'd15 ? 8'h22 : aw == 4'd0 ? 8'h33 : aw == 4'd1 ? 8'h44 : 8'h00;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic fbit(input logic [7:0] b, input int p);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    return p < 2 ? 1'b1 : fr[(p-2)/4];
  endfunction
  function automatic logic [7:0] v3(input int q);
    return q == 0 ? 8'hA5 : q == 1 ? 8'h3C : 8'hFF;
  endfunction
  function automatic logic [7:0] vw(input int q);
    return q == 0 ? 8'h11 : q == 1 ? 8'h22 : q == 2 ? 8'h33 : 8'h44;
  endfunction
  task automatic frame1();
    for (int c = 0; c < 48; c++) begin
      @(negedge clock);
      chk("u1_tx", t1, c < 42 ? fbit(8'hA5, c) : 1'b1);
      chk("u1_busy", b1, c < 42);
      chk("u1_done", o1, c >= 42);
    end
  endtask
  task automatic run3(input int drop);
    int p, q;
    logic [7:0] rx;
    for (int c = 0; c < 131; c++) begin
      @(negedge clock);
      if (c == drop) s3 = 1'b0;
      p = c % 42;
      q = c / 42;
      if (c < 126) chk("u3_tx", t3, fbit(v3(q), p));
      if (c < 126 && p >= 8 && p <= 36 && (p - 8) % 4 == 0) rx[(p-8)/4] = t3;
      if (c < 126 && p == 40) chk("u3_rx", rx, v3(q));
      chk("u3_addr", a3, c < 126 ? q : 2);
      chk("u3_busy", b3, c < 126);
      chk("u3_done", o3, drop < 0 ? c >= 126 : c == 126);
    end
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_tx", t1, 1'b1);
    chk("rst_busy", b1, 1'b0);
    chk("rst_done", o1, 1'b0);
    chk("rst_addr", a1, 16'd0);
    chk("rst_addr_w", aw, 4'd14);
    r1 = 1'b0; r3 = 1'b0; rw = 1'b0;
    @(negedge clock);
    s1 = 1'b1;
    frame1();
    repeat (10) @(negedge clock);
    chk("u1_hold_done", o1, 1'b1);
    chk("u1_hold_busy", b1, 1'b0);
    s1 = 1'b0;
    @(negedge clock);
    chk("u1_exit_done", o1, 1'b0);
    s1 = 1'b1; r1 = 1'b1;
    @(negedge clock);
    r1 = 1'b0;
    frame1();
    repeat (60) @(negedge clock);
    chk("u1_no_retrig_busy", b1, 1'b0);
    chk("u1_no_retrig_done", o1, 1'b1);
    chk("u1_no_retrig_tx", t1, 1'b1);
    s1 = 1'b0;
    @(negedge clock);
    chk("u1_idle_done", o1, 1'b0);
    s1 = 1'b1;
    frame1();
    s1 = 1'b0;
    @(negedge clock);
    s1 = 1'b1;
    for (int c = 0; c < 20; c++) @(negedge clock);
    chk("u1_bit3_tx", t1, 1'b0);
    r1 = 1'b1;
    @(negedge clock);
    chk("u1_mrst_tx", t1, 1'b1);
    chk("u1_mrst_busy", b1, 1'b0);
    chk("u1_mrst_addr", a1, 16'd0);
    r1 = 1'b0;
    frame1();
    s3 = 1'b1;
    run3(-1);
    repeat (3) @(negedge clock);
    chk("u3_hold_done", o3, 1'b1);
    s3 = 1'b0;
    @(negedge clock);
    chk("u3_exit_done", o3, 1'b0);
    s3 = 1'b1;
    run3(50);
    s3 = 1'b1;
    for (int c = 0; c < 61; c++) @(negedge clock);
    chk("u3_mid_addr", a3, 16'd1);
    r3 = 1'b1;
    @(negedge clock);
    chk("u3_mrst_addr", a3, 16'd0);
    chk("u3_mrst_busy", b3, 1'b0);
    chk("u3_mrst_tx", t3, 1'b1);
    r3 = 1'b0; s3 = 1'b0;
    sw = 1'b1;
    for (int c = 0; c < 170; c++) begin
      @(negedge clock);
      chk("uw_addr", aw, c < 168 ? (14 + c / 42) % 16 : 1);
      if (c < 168) chk("uw_tx", tw, fbit(vw(c / 42), c % 42));
      chk("uw_busy", bw, c < 168);
      chk("uw_done", ow, c >= 168);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
